// File: rtl/des_pkg.sv
// DES S-box tables, P permutation and lookup helpers shared by the S-box engine and its lanes.
package des_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   // SBOX[box][row][col]: box 0 is S1; each row literal lists columns 0..15 left to right.
   localparam logic [0:7][0:3][0:15][3:0] SBOX = {
      64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
      64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
      64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
      64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
      64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
      64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
      64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
      64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
   };

   // P_IDX[i] is the 1-based (MSB = 1) source bit for output bit i+1.
   localparam logic [0:31][5:0] P_IDX = {
      6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
      6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
      6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
      6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
   };

   function automatic logic [3:0] des_sbox(input logic [2:0] box_idx, input logic [5:0] chunk6);
      return SBOX[box_idx][{chunk6[5], chunk6[0]}][chunk6[4:1]];
   endfunction

   function automatic logic [31:0] des_perm(input logic [31:0] x);
      logic [31:0] y;
      y = '0;
      for (int i = 0; i < 32; i++) y[31-i] = x[32-int'(P_IDX[i])];
      return y;
   endfunction

endpackage

// File: rtl/des_sbox_lane.sv
// One combinational DES S-box: box index and 6-bit chunk in, 4-bit nibble out.
module des_sbox_lane
   import des_pkg::*;
(
   input  logic [2:0] box,
   input  logic [5:0] chunk,
   output logic [3:0] nibble
);

   assign nibble = des_sbox(box, chunk);

endmodule

// File: rtl/des_sbox_engine.sv
// Time-multiplexed DES S1..S8 substitution: NUM_LANES boxes per cycle over 8/NUM_LANES cycles.
// Define DES_SBOX_PERM_EN to present P(S(x)) at the output instead of the raw S-box word.
module des_sbox_engine
   import des_pkg::*;
#(
   parameter int NUM_LANES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [47:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data
);

   localparam int ITER = 8 / NUM_LANES;
   localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

   if (!(NUM_LANES == 1 || NUM_LANES == 2 || NUM_LANES == 4 || NUM_LANES == 8)) begin : g_bad_lanes
      $error("des_sbox_engine: NUM_LANES must be 1, 2, 4 or 8");
   end

   // Handshakes: a word moves on any rising edge where valid and ready are both high;
   // out_valid/out_data stay stable until that edge, and in_ready is low outside IDLE.
   state_t          state;
   logic [CW-1:0]   cnt;
   logic [47:0]     cap;
   logic [31:0]     acc;
   logic [31:0]     acc_n;
   logic [2:0]      box   [NUM_LANES];
   logic [5:0]      chunk [NUM_LANES];
   logic [3:0]      nib   [NUM_LANES];

   always_comb begin
      for (int l = 0; l < NUM_LANES; l++) begin
         box[l]   = 3'(int'(cnt) * NUM_LANES + l);
         chunk[l] = cap[6*(7-int'(box[l])) +: 6];
      end
   end

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      des_sbox_lane u_lane (
         .box    (box[l]),
         .chunk  (chunk[l]),
         .nibble (nib[l])
      );
   end

   always_comb begin
      acc_n = acc;
      for (int l = 0; l < NUM_LANES; l++) acc_n[4*(7-int'(box[l])) +: 4] = nib[l];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         cnt       <= '0;
         cap       <= '0;
         acc       <= '0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  cap      <= in_data;
                  acc      <= '0;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               acc <= acc_n;
               if (cnt == CW'(ITER - 1)) begin
                  cnt       <= '0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DES_SBOX_PERM_EN
   assign out_data = des_perm(acc);
`else
   assign out_data = acc;
`endif

endmodule

// File: tb/tb_des_sbox_engine.sv
// Scoreboard bench for des_sbox_engine: directed FIPS vectors, back-pressure, mid-word reset, random traffic.
module tb_des_sbox_engine;

   parameter int NUM_LANES = 2;
   localparam int ITER = 8 / NUM_LANES;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [47:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;

   des_sbox_engine #(.NUM_LANES(NUM_LANES)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference tables in FIPS 46-3 layout: entry = row*16 + col.
   int sbt [8][64] = '{
      '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
      '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
      '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
      '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
      '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
      '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
      '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
      '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
   };
   int ptab [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                     2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};

   function automatic logic [31:0] ref_sbox(input logic [47:0] x);
      longint unsigned v;
      longint unsigned y;
      int ch, row, col;
      v = 64'(x);
      y = 0;
      for (int b = 0; b < 8; b++) begin
         ch  = int'((v >> (42 - 6*b)) % 64);
         row = (ch / 32) * 2 + (ch % 2);
         col = (ch / 2) % 16;
         y   = y * 16 + longint'(sbt[b][row*16 + col]);
      end
      return 32'(y);
   endfunction

   function automatic logic [31:0] ref_perm(input logic [31:0] s);
      longint unsigned v;
      longint unsigned y;
      v = 64'(s);
      y = 0;
      for (int i = 0; i < 32; i++) y = y * 2 + ((v >> (32 - ptab[i])) % 2);
      return 32'(y);
   endfunction

   function automatic logic [31:0] out_map(input logic [31:0] s);
`ifdef DES_SBOX_PERM_EN
      return ref_perm(s);
`else
      return s;
`endif
   endfunction

   int tests = 0;
   int fails = 0;
   int n_sent = 0;
   int n_out = 0;
   logic [31:0] exp_q[$];
   int          acc_q[$];
   bit          ready_rand = 0;
   logic        prev_ov = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Offer one word; the expected output is queued on the cycle the handshake is seen.
   task automatic send(input logic [47:0] x, input logic [31:0] exp, input bit keep);
      bit done;
      done = 0;
      in_data  = x;
      in_valid = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            done = 1;
            if (keep) begin
               exp_q.push_back(exp);
               acc_q.push_back(cyc + 1);
               n_sent++;
            end
         end
      end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout: in_ready stayed low for word %h", x);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = {16'($urandom), $urandom};
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 50 && !out_valid; i++) step(1);
      check("out_valid_rise", 32'(out_valid), 32'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 500 && exp_q.size() != 0; i++) step(1);
      check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && !prev_ov) begin
            if (acc_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL spurious_valid: out_valid rose with no accepted word, out_data=%h", out_data);
            end else begin
               check("latency", 32'(cyc - acc_q.pop_front()), 32'(ITER));
            end
         end
         if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_output: got %h, expected no output", out_data);
            end else begin
               check("out_data", out_data, exp_q.pop_front());
            end
         end
      end
      prev_ov = out_valid;
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (ready_rand) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #3000000;
      tests++;
      fails++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [47:0] x;
      logic [31:0] held;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      step(1);
      check("reset_in_ready", 32'(in_ready), 32'd0);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_data", out_data, 32'h0);
      step(1);
      rst = 1'b0;
      step(1);
      check("in_ready_after_reset", 32'(in_ready), 32'd1);

      out_ready = 1'b1;
      send(48'h0, out_map(32'hEFA72C4D), 1);
      send(48'hFFFF_FFFF_FFFF, out_map(32'hD9CE3DCB), 1);
      send(48'h0000_0000_0001, out_map(32'hEFA72C41), 1);
      drain();

      // Back-pressure: output must freeze while out_ready is low, and a one-cycle pulse releases it.
      out_ready = 1'b0;
      x = {16'($urandom), $urandom};
      send(x, ref_sbox(x) == 32'h0 ? out_map(32'h0) : out_map(ref_sbox(x)), 1);
      wait_valid();
      held     = out_data;
      in_valid = 1'b1;
      in_data  = ~x;
      for (int i = 0; i < 5; i++) begin
         step(1);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_out_data", out_data, held);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step(1);
      out_ready = 1'b0;
      check("bp_released_valid", 32'(out_valid), 32'd0);
      check("bp_released_in_ready", 32'(in_ready), 32'd1);
      check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
      out_ready = 1'b1;

      // Reset during the first BUSY cycle: the word is dropped.
      send(48'h1234_5678_9ABC, 32'h0, 0);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check("midrst_in_ready_low", 32'(in_ready), 32'd0);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      step(1);
      check("midrst_in_ready_back", 32'(in_ready), 32'd1);
      for (int i = 0; i < ITER + 2; i++) begin
         step(1);
         check("midrst_no_output", 32'(out_valid), 32'd0);
      end

      ready_rand = 1;
      for (int i = 0; i < 1500; i++) begin
         x = {16'($urandom), $urandom};
         send(x, out_map(ref_sbox(x)), 1);
         step($urandom_range(0, 3));
      end
      drain();
      ready_rand = 0;
      out_ready  = 1'b1;
      step(2);
      check("output_count", 32'(n_out), 32'(n_sent));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
